// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, PC select and memory-wait FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        REGF  = 2'b00,
        FWD_E = 2'b01,
        FWD_M = 2'b10,
        FWD_W = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_BR    = 2'b01,
        PC_JALR  = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mem_state_e;

endpackage

// File: rtl/haz_scoreboard.sv
// Pending-destination scoreboard and outstanding-count tracker for long-latency operations.
module haz_scoreboard #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned MAX_LONG = 4,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [AW-1:0]   issue_addr,
    input  logic            done,
    input  logic [AW-1:0]   done_addr,
    output logic [NREG-1:0] pend,
    output logic            full
);

    localparam int unsigned CW = $clog2(MAX_LONG + 1);

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [NREG-1:0] pend_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_next;
            cnt  <= cnt_next;
        end
    end

    // Clear before set so a same-register issue/done pair leaves the bit set; x0 never tracked.
    always_comb begin
        pend_next = pend;
        cnt_next  = cnt;
        if (done) begin
            pend_next[done_addr] = 1'b0;
        end
        if (issue && (issue_addr != '0)) begin
            pend_next[issue_addr] = 1'b1;
        end
        if (issue && !done && (cnt != CW'(MAX_LONG))) begin
            cnt_next = cnt + CW'(1);
        end else if (done && !issue && (cnt != '0)) begin
            cnt_next = cnt - CW'(1);
        end
    end

    assign full = (cnt == CW'(MAX_LONG));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use and scoreboard stalls, memory-wait freeze, redirect sequencing.
// Optional HAZ_PERF_CNT_EN adds saturating stall/freeze/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREG        = 32,
    parameter int unsigned MAX_LONG    = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    localparam int unsigned AW         = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] D_ADDR1,
    input  logic [AW-1:0] D_ADDR2,
    input  logic          D_USE1,
    input  logic          D_USE2,
    input  logic          D_LONG,
    input  logic [AW-1:0] E_WADDR,
    input  logic [AW-1:0] M_WADDR,
    input  logic [AW-1:0] W_WADDR,
    input  logic          E_WE,
    input  logic          M_WE,
    input  logic          W_WE,
    input  logic          E_LOAD,
    input  logic          LONG_ISSUE,
    input  logic          LONG_DONE,
    input  logic [AW-1:0] LONG_WADDR,
    input  logic          M_MEM,
    input  logic          MEM_ACK,
    input  logic          BR_TAKEN,
    input  logic          JALR_TAKEN,
    output logic [1:0]    FWD_RS1,
    output logic [1:0]    FWD_RS2,
    output logic          STALL_FD,
    output logic          BUBBLE_E,
    output logic          FLUSH_D,
    output logic          FREEZE,
    output logic [1:0]    PC_SEL,
    output logic          MEM_ERR,
    output logic          LONG_FULL
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]   STALL_CNT,
    output logic [31:0]   FREEZE_CNT,
    output logic [31:0]   FLUSH_CNT
`endif
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    mem_state_e    state;
    mem_state_e    state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          freeze_raw;
    logic          mem_err_raw;
    logic          freeze;

    logic          redir_pend;
    pc_sel_e       redir_sel;
    logic          live_redir;
    pc_sel_e       live_sel;

    logic [NREG-1:0] pend;
    logic            long_full;
    logic            load_use;
    logic            sb_stall;

    fwd_sel_e fwd1;
    fwd_sel_e fwd2;
    pc_sel_e  pc_sel;
    logic     stall;
    logic     bubble;
    logic     flush;

    function automatic fwd_sel_e fwd_for(
        input logic [AW-1:0] a,
        input logic [AW-1:0] ea,
        input logic          ev,
        input logic [AW-1:0] ma,
        input logic          mv,
        input logic [AW-1:0] wa,
        input logic          wv
    );
        if (ev && (ea != '0) && (a == ea)) return FWD_E;
        if (mv && (ma != '0) && (a == ma)) return FWD_M;
        if (wv && (wa != '0) && (a == wa)) return FWD_W;
        return REGF;
    endfunction

    // Memory-wait FSM: state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Memory-wait FSM: next state and freeze/error decode.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        freeze_raw  = 1'b0;
        mem_err_raw = 1'b0;
        case (state)
            RUN: begin
                if (M_MEM && !MEM_ACK) begin
                    freeze_raw = 1'b1;
                    state_next = WAIT;
                    timer_next = '0;
                end
            end
            WAIT: begin
                if (MEM_ACK) begin
                    state_next = RUN;
                end else begin
                    freeze_raw = 1'b1;
                    if (timer == TW'(MEM_TIMEOUT - 1)) begin
                        state_next = ERR;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
            end
            ERR: begin
                mem_err_raw = 1'b1;
                state_next  = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign freeze     = freeze_raw && !RST;
    assign live_redir = BR_TAKEN || JALR_TAKEN;
    assign live_sel   = JALR_TAKEN ? PC_JALR : PC_BR;

    // A redirect seen while frozen is held and replayed in the first unfrozen cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            redir_pend <= 1'b0;
            redir_sel  <= PC_PLUS4;
        end else if (freeze && live_redir) begin
            redir_pend <= 1'b1;
            redir_sel  <= live_sel;
        end else if (!freeze) begin
            redir_pend <= 1'b0;
        end
    end

    haz_scoreboard #(
        .NREG     (NREG),
        .MAX_LONG (MAX_LONG)
    ) u_scoreboard (
        .clk        (CLK),
        .rst        (RST),
        .issue      (LONG_ISSUE && !freeze),
        .issue_addr (E_WADDR),
        .done       (LONG_DONE && !freeze),
        .done_addr  (LONG_WADDR),
        .pend       (pend),
        .full       (long_full)
    );

    assign load_use = E_LOAD && (E_WADDR != '0) &&
                      ((D_USE1 && (D_ADDR1 == E_WADDR)) || (D_USE2 && (D_ADDR2 == E_WADDR)));
    assign sb_stall = (D_USE1 && pend[D_ADDR1]) || (D_USE2 && pend[D_ADDR2]) ||
                      (D_LONG && long_full);

    // Control priority: freeze, then redirect (held before live), then stall.
    always_comb begin
        fwd1   = REGF;
        fwd2   = REGF;
        pc_sel = PC_PLUS4;
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        if (!RST && !freeze) begin
            fwd1 = fwd_for(D_ADDR1, E_WADDR, E_WE && !E_LOAD, M_WADDR, M_WE, W_WADDR, W_WE);
            fwd2 = fwd_for(D_ADDR2, E_WADDR, E_WE && !E_LOAD, M_WADDR, M_WE, W_WADDR, W_WE);
            if (redir_pend) begin
                pc_sel = redir_sel;
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (live_redir) begin
                pc_sel = live_sel;
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (load_use || sb_stall) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    assign FWD_RS1   = fwd1;
    assign FWD_RS2   = fwd2;
    assign PC_SEL    = pc_sel;
    assign STALL_FD  = stall;
    assign BUBBLE_E  = bubble;
    assign FLUSH_D   = flush;
    assign FREEZE    = freeze;
    assign MEM_ERR   = mem_err_raw && !RST;
    assign LONG_FULL = long_full;

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CNT  <= '0;
            FREEZE_CNT <= '0;
            FLUSH_CNT  <= '0;
        end else begin
            if (stall && (STALL_CNT != '1)) begin
                STALL_CNT <= STALL_CNT + 32'd1;
            end
            if (freeze && (FREEZE_CNT != '1)) begin
                FREEZE_CNT <= FREEZE_CNT + 32'd1;
            end
            if (flush && (FLUSH_CNT != '1)) begin
                FLUSH_CNT <= FLUSH_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected outputs queued at drive time, compared at sample time.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] D_ADDR1, D_ADDR2, E_WADDR, M_WADDR, W_WADDR, LONG_WADDR;
    logic          D_USE1, D_USE2, D_LONG, E_WE, M_WE, W_WE, E_LOAD;
    logic          LONG_ISSUE, LONG_DONE, M_MEM, MEM_ACK, BR_TAKEN, JALR_TAKEN;
    logic [1:0]    FWD_RS1, FWD_RS2, PC_SEL;
    logic          STALL_FD, BUBBLE_E, FLUSH_D, FREEZE, MEM_ERR, LONG_FULL;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   STALL_CNT, FREEZE_CNT, FLUSH_CNT;
`endif

    always #5 CLK = ~CLK;

    hazard_ctrl #(.NREG(32), .MAX_LONG(4), .MEM_TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .D_ADDR1(D_ADDR1), .D_ADDR2(D_ADDR2), .D_USE1(D_USE1), .D_USE2(D_USE2), .D_LONG(D_LONG),
        .E_WADDR(E_WADDR), .M_WADDR(M_WADDR), .W_WADDR(W_WADDR),
        .E_WE(E_WE), .M_WE(M_WE), .W_WE(W_WE), .E_LOAD(E_LOAD),
        .LONG_ISSUE(LONG_ISSUE), .LONG_DONE(LONG_DONE), .LONG_WADDR(LONG_WADDR),
        .M_MEM(M_MEM), .MEM_ACK(MEM_ACK), .BR_TAKEN(BR_TAKEN), .JALR_TAKEN(JALR_TAKEN),
        .FWD_RS1(FWD_RS1), .FWD_RS2(FWD_RS2), .STALL_FD(STALL_FD), .BUBBLE_E(BUBBLE_E),
        .FLUSH_D(FLUSH_D), .FREEZE(FREEZE), .PC_SEL(PC_SEL), .MEM_ERR(MEM_ERR),
        .LONG_FULL(LONG_FULL)
`ifdef HAZ_PERF_CNT_EN
        , .STALL_CNT(STALL_CNT), .FREEZE_CNT(FREEZE_CNT), .FLUSH_CNT(FLUSH_CNT)
`endif
    );

    typedef struct packed {
        logic [1:0] f1;
        logic [1:0] f2;
        logic       st;
        logic       bu;
        logic       fl;
        logic       fr;
        logic [1:0] pc;
        logic       er;
        logic       full;
    } obs_t;

    int    errors = 0;
    int    checks = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic obs_t mk(input int f1, input int f2, input int st, input int bu, input int fl,
                                input int fr, input int pc, input int er, input int full);
        obs_t o;
        o.f1 = 2'(f1); o.f2 = 2'(f2); o.st = 1'(st); o.bu = 1'(bu); o.fl = 1'(fl);
        o.fr = 1'(fr); o.pc = 2'(pc); o.er = 1'(er); o.full = 1'(full);
        return o;
    endfunction

    task automatic clr();
        D_ADDR1 = '0; D_ADDR2 = '0; D_USE1 = 0; D_USE2 = 0; D_LONG = 0;
        E_WADDR = '0; M_WADDR = '0; W_WADDR = '0; E_WE = 0; M_WE = 0; W_WE = 0; E_LOAD = 0;
        LONG_ISSUE = 0; LONG_DONE = 0; LONG_WADDR = '0;
        M_MEM = 0; MEM_ACK = 0; BR_TAKEN = 0; JALR_TAKEN = 0;
    endtask

    // Inputs are already applied at the falling edge; queue expectation, sample mid-low-phase, advance.
    task automatic step(input string tag, input obs_t e);
        obs_t  got;
        obs_t  want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        got.f1 = FWD_RS1; got.f2 = FWD_RS2; got.st = STALL_FD; got.bu = BUBBLE_E;
        got.fl = FLUSH_D; got.fr = FREEZE; got.pc = PC_SEL; got.er = MEM_ERR; got.full = LONG_FULL;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        check_eq(t, 32'(got), 32'(want));
        @(negedge CLK);
    endtask

    obs_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST  = 1'b1;
        clr();
        @(negedge CLK);
        M_MEM = 1; E_WE = 1; E_WADDR = 5; D_ADDR1 = 5;
        step("reset_outputs", idle);
`ifdef HAZ_PERF_CNT_EN
        check_eq("freeze_cnt_reset", FREEZE_CNT, 32'd0);
`endif
        RST = 1'b0;

        // Forwarding
        clr(); D_ADDR1 = 5; D_ADDR2 = 5; D_USE1 = 1; D_USE2 = 1; E_WADDR = 5; E_WE = 1;
        step("fwd_e_both", mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        clr(); D_ADDR1 = 5; D_ADDR2 = 5; D_USE1 = 1; D_USE2 = 1; E_WADDR = 0; E_WE = 1;
        step("fwd_e_waddr0", idle);
        clr(); D_USE1 = 1; E_WADDR = 0; E_WE = 1; M_WADDR = 0; M_WE = 1;
        step("fwd_x0", idle);
        clr(); D_ADDR1 = 3; D_ADDR2 = 4; E_WADDR = 3; E_WE = 1; M_WADDR = 4; M_WE = 1; W_WADDR = 4; W_WE = 1;
        step("fwd_prio_e_m", mk(1, 2, 0, 0, 0, 0, 0, 0, 0));
        clr(); D_ADDR1 = 4; D_ADDR2 = 4; W_WADDR = 4; W_WE = 1; M_WADDR = 4;
        step("fwd_w", mk(3, 3, 0, 0, 0, 0, 0, 0, 0));

        // Load-use then forward from M
        clr(); E_LOAD = 1; E_WE = 1; E_WADDR = 7; D_USE2 = 1; D_ADDR2 = 7;
        step("load_use", mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        clr(); M_WE = 1; M_WADDR = 7; D_USE2 = 1; D_ADDR2 = 7;
        step("load_fwd_m", mk(0, 2, 0, 0, 0, 0, 0, 0, 0));

        // Scoreboard on x9
        clr(); LONG_ISSUE = 1; E_WADDR = 9;
        step("issue9", idle);
        clr(); D_USE1 = 1; D_ADDR1 = 9;
        step("sb_stall_a", mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        step("sb_stall_b", mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        LONG_DONE = 1; LONG_WADDR = 9;
        step("sb_stall_done", mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        clr(); D_USE1 = 1; D_ADDR1 = 9;
        step("sb_released", idle);

        // Fill to MAX_LONG
        for (int i = 0; i < 4; i++) begin
            clr(); LONG_ISSUE = 1; E_WADDR = AW'(10 + i);
            step($sformatf("fill_%0d", i), idle);
        end
        clr(); D_LONG = 1;
        step("full_dlong", mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
        clr(); LONG_ISSUE = 1; E_WADDR = 20; LONG_DONE = 1; LONG_WADDR = 10; D_USE1 = 1; D_ADDR1 = 10;
        step("issue_done_same", mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
        clr(); D_USE1 = 1; D_ADDR1 = 10;
        step("x10_cleared", mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        clr(); D_USE2 = 1; D_ADDR2 = 20;
        step("x20_pending", mk(0, 0, 1, 1, 0, 0, 0, 0, 1));
        clr(); LONG_DONE = 1; LONG_WADDR = 11;
        step("drain_11", mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        clr(); LONG_DONE = 1; LONG_WADDR = 12;
        step("drain_12", idle);
        clr(); LONG_DONE = 1; LONG_WADDR = 13;
        step("drain_13", idle);
        clr(); LONG_DONE = 1; LONG_WADDR = 20;
        step("drain_20", idle);
        clr(); LONG_ISSUE = 1; E_WADDR = 0;
        step("issue_x0", idle);
        clr(); D_USE1 = 1; D_ADDR1 = 0;
        step("x0_never_pend", idle);
        clr(); LONG_DONE = 1; LONG_WADDR = 0;
        step("drain_x0", idle);

        // Redirect priority
        clr(); BR_TAKEN = 1; JALR_TAKEN = 1; E_LOAD = 1; E_WADDR = 6; D_USE1 = 1; D_ADDR1 = 6;
        step("jalr_wins", mk(0, 0, 0, 1, 1, 0, 2, 0, 0));
        clr(); BR_TAKEN = 1;
        step("br_only", mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
        clr(); M_MEM = 1; MEM_ACK = 1;
        step("zero_wait", idle);

        // Freeze with ACK after 3 cycles, redirect replayed after
        clr(); M_MEM = 1;
        step("frz_0", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        clr(); M_MEM = 1; BR_TAKEN = 1; LONG_ISSUE = 1; E_WADDR = 15;
        step("frz_1_br", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        clr(); M_MEM = 1; E_WE = 1; E_WADDR = 5; D_ADDR1 = 5; E_LOAD = 0;
        step("frz_2_masked", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        clr(); M_MEM = 1; MEM_ACK = 1;
        step("ack_redirect", mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
        clr(); D_USE1 = 1; D_ADDR1 = 15;
        step("after_redirect", idle);

        // Timeout: 9 frozen cycles then a single error pulse
        for (int i = 0; i < 9; i++) begin
            clr(); M_MEM = 1;
            step($sformatf("tmo_frz_%0d", i), mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        clr();
        step("tmo_err", mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        step("tmo_err_gone", idle);
`ifdef HAZ_PERF_CNT_EN
        check_eq("freeze_cnt_total", FREEZE_CNT, 32'd12);
`endif

        // Reset in WAIT discards pending redirect
        clr(); M_MEM = 1;
        step("rw_frz", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        clr(); M_MEM = 1; JALR_TAKEN = 1;
        step("rw_frz_jalr", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        clr(); M_MEM = 1; RST = 1'b1;
        step("rw_in_reset", idle);
        RST = 1'b0;
        clr();
        step("rw_after_reset", idle);
`ifdef HAZ_PERF_CNT_EN
        check_eq("freeze_cnt_rerst", FREEZE_CNT, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised next-generation hazard unit for the five-stage RISC-V core. Sits beside the pipeline registers and drives forwarding selects, stall, bubble, freeze and PC-redirect controls. Extends plain load-use and forwarding detection with three features:
- a register scoreboard for multi-cycle (long-latency) operations,
- a variable-latency data-memory wait FSM with timeout,
- redirect sequencing across freezes.

## Interface
Parameters:
- NREG, 32: architectural register count; address width AW = $clog2(NREG).
- MAX_LONG, 4: maximum outstanding long-latency ops.
- MEM_TIMEOUT, 255: wait cycles before a memory access is abandoned.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  core clock.
- RST  in  1  asynchronous active-high reset.
- D_ADDR1, D_ADDR2  in  AW  decode source registers.
- D_USE1, D_USE2  in  1  decode instruction really reads rs1/rs2.
- D_LONG  in  1  decode instruction is a long-latency op.
- E_WADDR, M_WADDR, W_WADDR  in  AW  destination per stage.
- E_WE, M_WE, W_WE  in  1  stage writes its destination.
- E_LOAD  in  1  execute holds a load.
- LONG_ISSUE  in  1  long op leaves E this cycle; destination is E_WADDR.
- LONG_DONE  in  1  long op result written back.
- LONG_WADDR  in  AW  destination of the completing long op.
- M_MEM  in  1  memory stage holds a load or store.
- MEM_ACK  in  1  data memory completes the access.
- BR_TAKEN, JALR_TAKEN  in  1  redirect resolved in E.
- FWD_RS1, FWD_RS2  out  2  00 regfile, 01 E, 10 M, 11 W.
- STALL_FD  out  1  hold PC and the F/D register.
- BUBBLE_E  out  1  insert a NOP into D/E.
- FLUSH_D  out  1  clear F/D.
- FREEZE  out  1  hold every pipeline register.
- PC_SEL  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target.
- MEM_ERR  out  1  one-cycle timeout pulse.
- LONG_FULL  out  1  outstanding count equals MAX_LONG.

## Operation
Forwarding:
- Applies per source operand.
- Forward from E when ADDRn == E_WADDR && E_WE && !E_LOAD && E_WADDR != 0.
- Otherwise forward from M, then W, under the same rule.
- Register x0 is never forwarded.

Load-use:
- Triggered by D_USEn && D_ADDRn == E_WADDR && E_LOAD && E_WADDR != 0.
- Response: STALL_FD=1, BUBBLE_E=1.

Scoreboard:
- pend[NREG-1:0] is set on LONG_ISSUE and cleared on LONG_DONE.
- If LONG_ISSUE and LONG_DONE target the same register in one cycle, set wins.
- cnt (0..MAX_LONG) increments on issue and decrements on done. Simultaneous issue and done leave cnt unchanged.
- Decode stalls (STALL_FD=1, BUBBLE_E=1) when D_USEn && pend[D_ADDRn], or when D_LONG && LONG_FULL.
- pend[0] never sets.

Memory FSM, states RUN, WAIT, ERR:
- RUN: FREEZE = M_MEM && !MEM_ACK. If FREEZE, go to WAIT and clear timer.
- WAIT: FREEZE=1 until MEM_ACK, then return to RUN with FREEZE=0 in the ACK cycle. If timer reaches MEM_TIMEOUT without ACK, go to ERR.
- ERR: FREEZE=0, MEM_ERR=1 for exactly one cycle, then RUN.

Priority, highest first:
1. FREEZE: all other controls forced to 0 and scoreboard updates ignored.
2. Redirect: PC_SEL=01 for BR_TAKEN, 10 for JALR_TAKEN (JALR wins if both); FLUSH_D=1, BUBBLE_E=1, STALL_FD=0.
3. Stall (load-use or scoreboard).
4. Normal forwarding.

Redirect during freeze:
- A redirect asserted while FREEZE=1 is latched in redir_pend together with its PC_SEL.
- It is issued in the first unfrozen cycle, then cleared.

## Timing
- Forwarding, stall and redirect outputs are combinational from the current-cycle inputs and registered state.
- Scoreboard, cnt, FSM and redir_pend update on the rising edge of CLK.
- Reset values:
  - Registered state: pend=0, cnt=0, state=RUN, timer=0, redir_pend=0.
  - Outputs: FWD_RS*=00, STALL_FD=0, BUBBLE_E=0, FLUSH_D=0, FREEZE=0, PC_SEL=00, MEM_ERR=0, LONG_FULL=0.
- RST asserted mid-WAIT or mid-ERR returns to RUN immediately and discards any latched redirect.
- Zero-wait memory (ACK in the same cycle as M_MEM) produces no freeze.

## Configuration
- HAZ_PERF_CNT_EN defined: adds 32-bit outputs STALL_CNT, FREEZE_CNT and FLUSH_CNT.
  - Each counts cycles with STALL_FD, FREEZE or FLUSH_D high respectively.
  - Counters saturate at all-ones and reset to 0.
- HAZ_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package hazard_pkg holds the fwd_sel_e encoding (REGF, FWD_E, FWD_M, FWD_W), the pc_sel_e encoding and the mem_state_e FSM enum.
- One sub-module, haz_scoreboard (pend vector, cnt, LONG_FULL), is instantiated once.
- Forwarding and priority logic stay in hazard_ctrl.

## Test plan
- E writes x5 (ALU), D reads x5 as rs1 and rs2 -> FWD_RS1=FWD_RS2=01. Same case with E_WADDR=0 -> 00.
- E_LOAD writing x7, D_USE2 with D_ADDR2=7 -> STALL_FD=1, BUBBLE_E=1 for one cycle. Next cycle with the load in M -> FWD_RS2=10.
- LONG_ISSUE to x9; D reads x9 -> stall each cycle until LONG_DONE x9; the following cycle shows no stall. With MAX_LONG=4, four issues -> LONG_FULL=1 and D_LONG stalls.
- M_MEM with MEM_ACK after 3 cycles -> FREEZE high for 3 cycles. BR_TAKEN during the freeze -> PC_SEL=01, FLUSH_D=1 in the first unfrozen cycle only.
- M_MEM with MEM_TIMEOUT=8 and no ACK -> FREEZE high for 9 cycles, then MEM_ERR pulses for 1 cycle with FREEZE=0.
- RST asserted in WAIT -> all outputs 0 and state RUN within the same cycle. With HAZ_PERF_CNT_EN defined, FREEZE_CNT reads 0 after reset.
